// File: rtl/outpkt_multi_record.sv
// Packs up to RECORDS_PER_PKT same-id records into one packet (header, header checksum,
// payload, payload checksum) and streams it as 16-bit words through an FWFT read port.
module outpkt_multi_record #(
  parameter logic [7:0]  VERSION         = 8'd2,
  parameter logic [7:0]  PKT_TYPE        = 8'h81,
  parameter int unsigned REC_BYTES       = 14,
  parameter int unsigned RECORDS_PER_PKT = 4,
  parameter int unsigned TIMEOUT         = 256
) (
  input  logic                   CLK,
  input  logic                   rst,
  input  logic [REC_BYTES*8-1:0] din,
  input  logic [15:0]            pkt_id_in,
  input  logic                   wr_en,
  output logic                   full,
  output logic [15:0]            dout,
  input  logic                   rd_en,
  output logic                   empty,
  output logic                   pkt_end,
  output logic [15:0]            pkt_count
);

  localparam int unsigned RecW        = REC_BYTES * 8;
  localparam int unsigned WordsPerRec = REC_BYTES / 2;
  localparam int unsigned CntW        = $clog2(RECORDS_PER_PKT + 1);
  localparam int unsigned SlotW       = (RECORDS_PER_PKT > 1) ? $clog2(RECORDS_PER_PKT) : 1;
  localparam int unsigned WrdW        = (WordsPerRec > 1) ? $clog2(WordsPerRec) : 1;
  localparam int unsigned IdleW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {StFill, StHdr, StHcs, StData, StDcs} state_e;

  state_e            state_q;
  logic [CntW-1:0]   count_q;
  logic [15:0]       cur_id_q;
  logic              pend_valid_q;
  logic [15:0]       pend_id_q;
  logic [IdleW-1:0]  idle_q;
  logic [31:0]       acc_q;
  logic              half_q;
  logic [2:0]        idx_q;
  logic [SlotW-1:0]  rec_q;
  logic [WrdW-1:0]   wrd_q;
  logic [15:0]       dout_q;
  logic              pkt_end_q;
  logic              empty_q;
  logic [15:0]       pkt_count_q;
  logic [RecW-1:0]   buf_q [RECORDS_PER_PKT];
  logic [RecW-1:0]   pend_rec_q;

  logic        wr_acc, id_match, wr_new, wr_same, wr_pend, fills_up, timeout_hit, flush;
  logic        pop, pop_last, load, seq_valid, seq_last;
  logic [15:0] seq_word, rec_word;
  logic [23:0] len;
  logic [31:0] acc_add;

  assign full      = (state_q != StFill) | pend_valid_q;
  assign dout      = dout_q;
  assign empty     = empty_q;
  assign pkt_end   = pkt_end_q;
  assign pkt_count = pkt_count_q;

  assign wr_acc      = wr_en & ~full;
  assign id_match    = (pkt_id_in == cur_id_q);
  assign wr_new      = wr_acc & (count_q == '0);
  assign wr_same     = wr_acc & (count_q != '0) & id_match;
  assign wr_pend     = wr_acc & (count_q != '0) & ~id_match;
  assign fills_up    = (wr_new | wr_same) &
                       ((count_q + CntW'(1)) == CntW'(RECORDS_PER_PKT));
  // A same-cycle write beats the idle timeout.
  assign timeout_hit = (TIMEOUT != 0) & (state_q == StFill) & (count_q != '0) & ~wr_acc &
                       (idle_q == IdleW'(TIMEOUT));
  assign flush       = wr_pend | fills_up | timeout_hit;

  assign pop      = rd_en & ~empty_q;
  assign pop_last = pop & pkt_end_q;
  assign len      = 24'(count_q) * 24'(REC_BYTES);
  assign rec_word = 16'(buf_q[rec_q] >> {wrd_q, 4'b0000});

  always_comb begin
    seq_valid = 1'b0;
    seq_last  = 1'b0;
    seq_word  = '0;
    case (state_q)
      StHdr: begin
        seq_valid = 1'b1;
        case (idx_q)
          3'd0:    seq_word = {PKT_TYPE, VERSION};
          3'd1:    seq_word = 16'h0000;
          3'd2:    seq_word = len[15:0];
          3'd3:    seq_word = {8'h00, len[23:16]};
          default: seq_word = cur_id_q;
        endcase
      end
      StHcs: begin
        seq_valid = 1'b1;
        seq_word  = idx_q[0] ? ~acc_q[31:16] : ~acc_q[15:0];
      end
      StData: begin
        seq_valid = 1'b1;
        seq_word  = rec_word;
      end
      StDcs: begin
        // idx 2 means both checksum words are out; wait for the last one to be consumed.
        seq_valid = ~idx_q[1];
        seq_last  = idx_q[0];
        seq_word  = idx_q[0] ? ~acc_q[31:16] : ~acc_q[15:0];
      end
      default: ;
    endcase
  end

  assign load    = seq_valid & (empty_q | rd_en);
  assign acc_add = half_q ? {seq_word, 16'h0000} : {16'h0000, seq_word};

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q      <= StFill;
      count_q      <= '0;
      cur_id_q     <= '0;
      pend_valid_q <= 1'b0;
      pend_id_q    <= '0;
      idle_q       <= '0;
      acc_q        <= '0;
      half_q       <= 1'b0;
      idx_q        <= '0;
      rec_q        <= '0;
      wrd_q        <= '0;
      dout_q       <= '0;
      pkt_end_q    <= 1'b0;
      empty_q      <= 1'b1;
      pkt_count_q  <= '0;
    end else begin
      if (load) begin
        dout_q    <= seq_word;
        pkt_end_q <= seq_last;
        empty_q   <= 1'b0;
      end else if (pop) begin
        pkt_end_q <= 1'b0;
        empty_q   <= 1'b1;
      end
      if (pop_last) pkt_count_q <= pkt_count_q + 16'd1;

      if ((state_q != StFill) || wr_acc) begin
        idle_q <= '0;
      end else if ((count_q != '0) && (idle_q != IdleW'(TIMEOUT))) begin
        idle_q <= idle_q + IdleW'(1);
      end

      case (state_q)
        StFill: begin
          if (wr_new) begin
            cur_id_q <= pkt_id_in;
            count_q  <= CntW'(1);
          end else if (wr_same) begin
            count_q <= count_q + CntW'(1);
          end
          if (wr_pend) begin
            pend_valid_q <= 1'b1;
            pend_id_q    <= pkt_id_in;
          end
          if (flush) begin
            state_q <= StHdr;
            idx_q   <= '0;
            acc_q   <= '0;
            half_q  <= 1'b0;
          end
        end
        StHdr: begin
          if (load) begin
            acc_q  <= acc_q + acc_add;
            half_q <= ~half_q;
            if (idx_q == 3'd4) begin
              state_q <= StHcs;
              idx_q   <= '0;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end
        StHcs: begin
          if (load) begin
            if (idx_q[0]) begin
              state_q <= StData;
              acc_q   <= '0;
              half_q  <= 1'b0;
              rec_q   <= '0;
              wrd_q   <= '0;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end
        StData: begin
          if (load) begin
            acc_q  <= acc_q + acc_add;
            half_q <= ~half_q;
            if (wrd_q == WrdW'(WordsPerRec - 1)) begin
              wrd_q <= '0;
              if (CntW'(rec_q) == (count_q - CntW'(1))) begin
                state_q <= StDcs;
                idx_q   <= '0;
              end else begin
                rec_q <= rec_q + SlotW'(1);
              end
            end else begin
              wrd_q <= wrd_q + WrdW'(1);
            end
          end
        end
        StDcs: begin
          if (load) idx_q <= idx_q + 3'd1;
          if (pop_last) begin
            state_q <= StFill;
            if (pend_valid_q) begin
              cur_id_q     <= pend_id_q;
              count_q      <= CntW'(1);
              pend_valid_q <= 1'b0;
            end else begin
              count_q <= '0;
            end
          end
        end
        default: state_q <= StFill;
      endcase
    end
  end

  // Record storage needs no reset: count_q alone decides which slots are live.
  always_ff @(posedge CLK) begin
    if (pop_last && pend_valid_q) begin
      buf_q[0] <= pend_rec_q;
    end else if (wr_new) begin
      buf_q[0] <= din;
    end else if (wr_same) begin
      buf_q[SlotW'(count_q)] <= din;
    end
    if (wr_pend) pend_rec_q <= din;
  end

endmodule

// File: tb/tb_outpkt_multi_record.sv
// Bench for outpkt_multi_record: directed sequence with random record contents, checked
// against a byte-level packet model.
module tb_outpkt_multi_record;

  logic          CLK = 1'b0;
  logic          rst = 1'b1;
  logic [111:0]  din = '0;
  logic [15:0]   pkt_id_in = '0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic          full, empty, pkt_end;
  logic [15:0]   dout, pkt_count;

  logic [111:0]  din6 = '0;
  logic [15:0]   pkt_id6 = '0;
  logic          wr_en6 = 1'b0;
  logic          rd_en6 = 1'b1;
  logic          full6, empty6, pkt_end6;
  logic [15:0]   dout6, pkt_count6;

  int            tests = 0;
  int            fails = 0;
  bit            rd_rand = 1'b0;
  bit            rd_fix = 1'b0;
  logic [16:0]   exp_q[$];
  logic [16:0]   exp6_q[$];
  logic [15:0]   log_q[$];
  logic [15:0]   t1_log[$];
  logic [15:0]   log6[$];
  logic [111:0]  mrec[4];
  logic [111:0]  t1rec[4];

  outpkt_multi_record u_dut (
    .CLK       (CLK),
    .rst       (rst),
    .din       (din),
    .pkt_id_in (pkt_id_in),
    .wr_en     (wr_en),
    .full      (full),
    .dout      (dout),
    .rd_en     (rd_en),
    .empty     (empty),
    .pkt_end   (pkt_end),
    .pkt_count (pkt_count)
  );

  outpkt_multi_record #(
    .TIMEOUT         (0),
    .RECORDS_PER_PKT (2)
  ) u_dut6 (
    .CLK       (CLK),
    .rst       (rst),
    .din       (din6),
    .pkt_id_in (pkt_id6),
    .wr_en     (wr_en6),
    .full      (full6),
    .dout      (dout6),
    .rd_en     (rd_en6),
    .empty     (empty6),
    .pkt_end   (pkt_end6),
    .pkt_count (pkt_count6)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [111:0] rnd_rec();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[111:0];
  endfunction

  // Inverted sum of little-endian 32-bit words, last word zero-padded.
  function automatic logic [31:0] inv_sum(input logic [7:0] b[$]);
    logic [31:0] s;
    logic [31:0] w;
    s = '0;
    for (int i = 0; i < b.size(); i += 4) begin
      w = '0;
      for (int k = 0; k < 4; k++) begin
        if (i + k < b.size()) w = w | (32'(b[i+k]) << (8 * k));
      end
      s = s + w;
    end
    return ~s;
  endfunction

  function automatic void push_w(input bit to6, input bit pe, input logic [15:0] w);
    if (to6) exp6_q.push_back({pe, w});
    else     exp_q.push_back({pe, w});
  endfunction

  task automatic model_pkt(input int n, input logic [15:0] id, input bit to6);
    logic [7:0]  hb[$];
    logic [7:0]  pb[$];
    logic [23:0] len;
    logic [31:0] c;
    len = 24'(n * 14);
    hb = '{8'h02, 8'h81, 8'h00, 8'h00, len[7:0], len[15:8], len[23:16], 8'h00,
           id[7:0], id[15:8]};
    for (int i = 0; i < 5; i++) push_w(to6, 1'b0, {hb[2*i+1], hb[2*i]});
    c = inv_sum(hb);
    push_w(to6, 1'b0, c[15:0]);
    push_w(to6, 1'b0, c[31:16]);
    for (int r = 0; r < n; r++)
      for (int k = 0; k < 14; k++) pb.push_back(mrec[r][8*k +: 8]);
    for (int i = 0; i < pb.size() / 2; i++) push_w(to6, 1'b0, {pb[2*i+1], pb[2*i]});
    c = inv_sum(pb);
    push_w(to6, 1'b0, c[15:0]);
    push_w(to6, 1'b1, c[31:16]);
  endtask

  task automatic write(input logic [111:0] d, input logic [15:0] id);
    din       = d;
    pkt_id_in = id;
    wr_en     = 1'b1;
    tick();
    wr_en     = 1'b0;
  endtask

  task automatic write6(input logic [111:0] d, input logic [15:0] id);
    din6    = d;
    pkt_id6 = id;
    wr_en6  = 1'b1;
    tick();
    wr_en6  = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !empty) && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_drain_in_time"}, 32'(n < budget), 32'd1);
  endtask

  initial begin : rd_driver
    forever begin
      @(posedge CLK);
      #1;
      rd_en = rd_rand ? ($urandom_range(0, 99) < 30) : rd_fix;
    end
  end

  initial begin : monitor
    logic [15:0] prev_dout;
    logic        prev_pe;
    logic        prev_stall;
    logic [16:0] e;
    prev_dout  = '0;
    prev_pe    = 1'b0;
    prev_stall = 1'b0;
    forever begin
      @(negedge CLK);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_empty", 32'(empty), 32'd0);
          check("stall_dout", 32'(dout), 32'(prev_dout));
          check("stall_pkt_end", 32'(pkt_end), 32'(prev_pe));
        end
        if (!empty && rd_en) begin
          tests++;
          assert (exp_q.size() != 0) else begin
            fails++;
            $error("FAIL unexpected_word: got %h expected no word", dout);
          end
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("word", 32'(dout), 32'(e[15:0]));
            check("pkt_end", 32'(pkt_end), 32'(e[16]));
          end
          log_q.push_back(dout);
        end
        prev_stall = !empty && !rd_en;
        prev_dout  = dout;
        prev_pe    = pkt_end;
      end
    end
  end

  initial begin : main
    logic [111:0] r1, r2, r3, r6a, r6b;
    logic [16:0]  e;
    bit           saw;
    int           n;

    repeat (3) tick();
    rst = 1'b0;
    check("rst_full", 32'(full), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_pkt_end", 32'(pkt_end), 32'd0);
    check("rst_pkt_count", 32'(pkt_count), 32'd0);
    rd_fix = 1'b1;
    tick();

    // Test 1: four records, same id, back to back.
    log_q.delete();
    for (int i = 0; i < 4; i++) begin
      t1rec[i] = rnd_rec();
      mrec[i]  = t1rec[i];
    end
    model_pkt(4, 16'h0005, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("t1_full_before_write", 32'(full), 32'd0);
      write(t1rec[i], 16'h0005);
    end
    check("t1_full_after_4th", 32'(full), 32'd1);
    wait_drain(200, "t1");
    check("t1_words", 32'(log_q.size()), 32'd37);
    check("t1_hdr0", 32'(log_q[0]), 32'h8102);
    check("t1_hdr1", 32'(log_q[1]), 32'h0000);
    check("t1_hdr2", 32'(log_q[2]), 32'h0038);
    check("t1_hdr3", 32'(log_q[3]), 32'h0000);
    check("t1_hdr4", 32'(log_q[4]), 32'h0005);
    check("t1_hcs_lo", 32'(log_q[5]), 32'h7EC0);
    check("t1_hcs_hi", 32'(log_q[6]), 32'hFFFF);
    check("t1_pkt_count", 32'(pkt_count), 32'd1);
    t1_log = log_q;

    // Test 2: single record flushed by the idle timeout.
    log_q.delete();
    r1 = rnd_rec();
    write(r1, 16'h0007);
    repeat (255) tick();
    @(negedge CLK);
    check("t2_quiet_256", 32'(empty), 32'd1);
    mrec[0] = r1;
    model_pkt(1, 16'h0007, 1'b0);
    wait_drain(100, "t2");
    check("t2_words", 32'(log_q.size()), 32'd16);
    check("t2_len", 32'(log_q[2]), 32'h000E);
    check("t2_pkt_count", 32'(pkt_count), 32'd2);

    // Test 3: id change parks the third record until the first packet is gone.
    log_q.delete();
    r1 = rnd_rec();
    r2 = rnd_rec();
    r3 = rnd_rec();
    mrec[0] = r1;
    mrec[1] = r2;
    model_pkt(2, 16'h0001, 1'b0);
    mrec[0] = r3;
    model_pkt(1, 16'h0002, 1'b0);
    write(r1, 16'h0001);
    write(r2, 16'h0001);
    write(r3, 16'h0002);
    check("t3_full_after_mismatch", 32'(full), 32'd1);
    saw = 1'b0;
    n = 0;
    while (pkt_count == 16'd2 && n < 200) begin
      if (!full) saw = 1'b1;
      tick();
      n++;
    end
    check("t3_first_pkt_in_time", 32'(n < 200), 32'd1);
    check("t3_full_held", 32'(saw), 32'd0);
    check("t3_full_released", 32'(full), 32'd0);
    wait_drain(400, "t3");
    check("t3_words", 32'(log_q.size()), 32'd39);
    check("t3_len1", 32'(log_q[2]), 32'h001C);
    check("t3_len2", 32'(log_q[25]), 32'h000E);
    check("t3_id2", 32'(log_q[27]), 32'h0002);
    check("t3_pkt_count", 32'(pkt_count), 32'd4);

    // Test 4: test 1 again with a 30% read duty.
    log_q.delete();
    for (int i = 0; i < 4; i++) mrec[i] = t1rec[i];
    model_pkt(4, 16'h0005, 1'b0);
    rd_rand = 1'b1;
    for (int i = 0; i < 4; i++) write(t1rec[i], 16'h0005);
    wait_drain(2000, "t4");
    rd_rand = 1'b0;
    check("t4_words", 32'(log_q.size()), 32'(t1_log.size()));
    for (int i = 0; i < t1_log.size(); i++) check("t4_same_stream", 32'(log_q[i]), 32'(t1_log[i]));
    check("t4_pkt_count", 32'(pkt_count), 32'd5);

    // Test 5: reset in the middle of the payload.
    log_q.delete();
    for (int i = 0; i < 4; i++) mrec[i] = rnd_rec();
    model_pkt(4, 16'h00A5, 1'b0);
    for (int i = 0; i < 4; i++) write(mrec[i], 16'h00A5);
    n = 0;
    while (log_q.size() < 10 && n < 100) begin
      tick();
      n++;
    end
    check("t5_reach_data", 32'(n < 100), 32'd1);
    rst = 1'b1;
    #1;
    check("t5_rst_empty", 32'(empty), 32'd1);
    check("t5_rst_full", 32'(full), 32'd0);
    check("t5_rst_pkt_count", 32'(pkt_count), 32'd0);
    exp_q.delete();
    log_q.delete();
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) mrec[i] = rnd_rec();
    model_pkt(4, 16'h0033, 1'b0);
    for (int i = 0; i < 4; i++) write(mrec[i], 16'h0033);
    wait_drain(200, "t5");
    check("t5_words", 32'(log_q.size()), 32'd37);
    check("t5_pkt_count", 32'(pkt_count), 32'd1);

    // Test 6: no idle flush when TIMEOUT is 0; packet closes on the 2nd record.
    r6a = rnd_rec();
    r6b = rnd_rec();
    write6(r6a, 16'h1234);
    saw = 1'b0;
    repeat (10000) begin
      tick();
      if (!empty6) saw = 1'b1;
    end
    check("t6_no_idle_flush", 32'(saw), 32'd0);
    mrec[0] = r6a;
    mrec[1] = r6b;
    model_pkt(2, 16'h1234, 1'b1);
    write6(r6b, 16'h1234);
    n = 0;
    while (exp6_q.size() != 0 && n < 200) begin
      @(negedge CLK);
      if (!empty6) begin
        e = exp6_q.pop_front();
        check("t6_word", 32'(dout6), 32'(e[15:0]));
        check("t6_pkt_end", 32'(pkt_end6), 32'(e[16]));
        log6.push_back(dout6);
      end
      n++;
    end
    check("t6_in_time", 32'(n < 200), 32'd1);
    tick();
    tick();
    check("t6_words", 32'(log6.size()), 32'd23);
    check("t6_len", 32'(log6[2]), 32'h001C);
    check("t6_pkt_count", 32'(pkt_count6), 32'd1);
    check("t6_empty_after", 32'(empty6), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
